seven_segment_capture: RTL and testbench

//  Receive side of the 4-digit multiplexed seven-segment interface: samples active-low an/seg/dp

---
 rtl/seg_pkg.sv | 76 +++++++
 rtl/seg_pattern_decoder.sv | 37 +++
 rtl/seven_segment_capture.sv | 213 +++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture block.
//   seg_code_t   : 5-bit decoded digit code
//   CODE_*       : special codes for "=", dash, blank and unrecognised patterns
//   HEX_SEG      : active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//                  (the same table the display driver uses)
//   sample_t     : one registered sample of the an/seg/dp lines
//   state_t      : capture FSM states
// Optional feature macro used by importers: DP_CAPTURE_EN.
package seg_pkg;

  typedef logic [4:0] seg_code_t;

  localparam seg_code_t CODE_EQ    = 5'd16;
  localparam seg_code_t CODE_DASH  = 5'd17;
  localparam seg_code_t CODE_BLANK = 5'd18;
  localparam seg_code_t CODE_UNK   = 5'd31;

  localparam logic [6:0] SEG_EQ    = 7'b0110111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry [n] is the active-low pattern of hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sample_t;

  // All lines inactive: no digit enabled, all segments and dp dark.
  localparam sample_t SAMPLE_IDLE = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LATCH  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // True when exactly one anode line is driven low.
  function automatic logic is_one_hot_low(input logic [3:0] an_n);
    case (an_n)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Position of the low anode; only meaningful when is_one_hot_low().
  function automatic logic [1:0] low_index(input logic [3:0] an_n);
    case (an_n)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational decoder from an active-low segment pattern to a digit code.
// Ports:
//   seg     in  7  segments {g,f,e,d,c,b,a}, active low
//   code    out 5  0-15 hex, 16 "=", 17 dash, 18 blank, 31 unrecognised
//   unknown out 1  high when the pattern matches none of the above
module seg_pattern_decoder
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_code_t  code,
  output logic       unknown
);

  always_comb begin
    code    = CODE_UNK;
    unknown = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_SEG[i]) begin
        code    = seg_code_t'(i);
        unknown = 1'b0;
      end
    end
    if (seg == SEG_EQ) begin
      code    = CODE_EQ;
      unknown = 1'b0;
    end
    if (seg == SEG_DASH) begin
      code    = CODE_DASH;
      unknown = 1'b0;
    end
    if (seg == SEG_BLANK) begin
      code    = CODE_BLANK;
      unknown = 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a 4-digit multiplexed seven-segment display. Samples the
// active-low an/seg/dp lines, waits for each scanned digit to hold still for
// SETTLE_CYCLES samples, decodes it and latches one code per digit position.
//
// Parameters:
//   SETTLE_CYCLES  consecutive identical samples needed before a latch (>= 2)
//   CNT_W          settle counter width, must hold SETTLE_CYCLES
// Ports:
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   an           in   4   digit enables, active low
//   seg          in   7   segments {g,f,e,d,c,b,a}, active low
//   dp           in   1   decimal point, active low
//   digit_code   out  20  digit i code at [5i+4:5i]
//   digit_valid  out  4   bit i set once digit i latched since reset
//   frame_done   out  1   1-cycle pulse when all 4 digits latched since last pulse
//   decode_err   out  1   1-cycle pulse when a latched pattern is unrecognised
//   dp_flags     out  4   latched dp per digit, 1 = lit
//   state_dbg    out  2   current capture FSM state
// Build option: define DP_CAPTURE_EN to make dp part of the stability compare
// and to capture it into dp_flags; otherwise dp is ignored and dp_flags = 0.
//
// Output timing: there is no handshake. All outputs are registered and update
// together on the clock edge that ends the LATCH state; frame_done and
// decode_err are high for exactly that one following cycle. Inputs held
// constant from edge t produce the digit_code update at edge t+SETTLE_CYCLES+2.
module seven_segment_capture
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [19:0] digit_code,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        decode_err,
  output logic [3:0]  dp_flags,
  output state_t      state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Input sampler. prev_q trails sample_q by one cycle so a change can be
  // seen as sample_q != prev_q. Without dp capture the dp bit is forced
  // constant, which removes it from the compare entirely.
  // ---------------------------------------------------------------------
  sample_t sample_d;
  sample_t sample_q;
  sample_t prev_q;

`ifdef DP_CAPTURE_EN
  assign sample_d = '{an: an, seg: seg, dp: dp};
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign sample_d  = '{an: an, seg: seg, dp: 1'b1};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= SAMPLE_IDLE;
      prev_q   <= SAMPLE_IDLE;
    end else begin
      sample_q <= sample_d;
      prev_q   <= sample_q;
    end
  end

  logic changed;
  logic sample_one_hot;
  assign changed        = (sample_q != prev_q);
  assign sample_one_hot = is_one_hot_low(sample_q.an);

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             do_latch;
  state_t           restart_state;

  // Where to go whenever the sample moves: settle again if a single digit
  // is enabled, otherwise wait in IDLE.
  assign restart_state = sample_one_hot ? S_SETTLE : S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_latch = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sample_one_hot) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = restart_state;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        do_latch = 1'b1;
        cnt_d    = '0;
        // A change arriving during the latch cycle would be invisible from
        // HOLD (prev_q catches up), so restart settling directly.
        state_d  = changed ? restart_state : S_HOLD;
      end
      S_HOLD: begin
        cnt_d = '0;
        if (changed) begin
          state_d = restart_state;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

  // ---------------------------------------------------------------------
  // Latch datapath. In the LATCH cycle prev_q holds the settled pattern
  // regardless of what the sampler picked up on the last edge.
  // ---------------------------------------------------------------------
  seg_code_t dec_code;
  logic      dec_unknown;

  seg_pattern_decoder u_decoder (
    .seg     (prev_q.seg),
    .code    (dec_code),
    .unknown (dec_unknown)
  );

  logic [3:0][4:0] codes_q;
  logic [3:0]      valid_q;
  logic [3:0]      seen_q;
  logic [3:0]      latch_bit;
  logic [3:0]      seen_next;

  assign latch_bit = ~prev_q.an;
  assign seen_next = seen_q | latch_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      codes_q    <= {4{CODE_BLANK}};
      valid_q    <= '0;
      seen_q     <= '0;
      frame_done <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      decode_err <= 1'b0;
      if (do_latch) begin
        codes_q[low_index(prev_q.an)] <= dec_code;
        valid_q    <= valid_q | latch_bit;
        decode_err <= dec_unknown;
        if (seen_next == 4'b1111) begin
          frame_done <= 1'b1;
          seen_q     <= '0;
        end else begin
          seen_q <= seen_next;
        end
      end
    end
  end

  assign digit_code  = codes_q;
  assign digit_valid = valid_q;

`ifdef DP_CAPTURE_EN
  logic [3:0] dp_flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_flags_q <= '0;
    end else if (do_latch) begin
      dp_flags_q[low_index(prev_q.an)] <= ~prev_q.dp;
    end
  end

  assign dp_flags = dp_flags_q;
`else
  assign dp_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench for seven_segment_capture. A behavioural model tracks
// runs of constant input and predicts each latch; predictions are queued and
// a monitor compares them with the outputs after every latch.
// Honours DP_CAPTURE_EN the same way the design does.
module tb_seven_segment_capture;
  import seg_pkg::*;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [19:0] digit_code;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        decode_err;
  logic [3:0]  dp_flags;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  typedef struct packed {
    logic [19:0] code;
    logic [3:0]  valid;
    logic [3:0]  dpf;
    logic        frame;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Active-low {g,f,e,d,c,b,a} shapes of hex digits 0..F.
  logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state
  logic [3:0][4:0] m_code;
  logic [3:0]      m_valid;
  logic [3:0]      m_seen;
  logic [3:0]      m_dpf;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  int              r_len;

  seven_segment_capture dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digit_code  (digit_code),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .decode_err  (decode_err),
    .dp_flags    (dp_flags),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (p == hex_pat[i]) return i;
    if (p == 7'b0110111) return 16;
    if (p == 7'b0111111) return 17;
    if (p == 7'b1111111) return 18;
    return 31;
  endfunction

  function automatic logic one_hot(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic void model_reset();
    m_code  = {4{5'd18}};
    m_valid = '0;
    m_seen  = '0;
    m_dpf   = '0;
    r_an    = 4'hF;
    r_seg   = 7'h7F;
    r_dp    = 1'b1;
    r_len   = 0;
  endfunction

  function automatic void model_latch(input logic [3:0] a, input logic [6:0] s, input logic d);
    int   idx;
    int   c;
    exp_t e;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
    c = model_decode(s);
    m_code[idx]  = 5'(c);
    m_valid[idx] = 1'b1;
`ifdef DP_CAPTURE_EN
    m_dpf[idx]   = ~d;
`else
    if (d) m_dpf = m_dpf;
`endif
    m_seen[idx]  = 1'b1;
    e.frame = (m_seen == 4'hF);
    if (e.frame) m_seen = '0;
    e.code  = m_code;
    e.valid = m_valid;
    e.dpf   = m_dpf;
    e.err   = (c == 31);
    exp_q.push_back(e);
  endfunction

  // Call at a negedge; inputs are presented for exactly h rising edges.
  // A run of identical input that covers SETTLE+1 edges is a latch.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int h);
    logic same;
    an = a; seg = s; dp = d;
`ifdef DP_CAPTURE_EN
    same = (a == r_an) && (s == r_seg) && (d == r_dp);
`else
    same = (a == r_an) && (s == r_seg);
`endif
    if (!same) begin
      r_an = a; r_seg = s; r_dp = d; r_len = 0;
    end
    for (int k = 0; k < h; k++) begin
      @(negedge clk);
      r_len++;
      if (r_len == S + 1 && one_hot(a)) model_latch(a, s, d);
    end
  endtask

  // Call at a negedge; asserts reset between edges, checks the outputs
  // cleared without a clock edge, then releases at a later negedge.
  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_code"},  digit_code, {4{5'd18}});
    chk({tag, "_valid"}, digit_valid, 4'h0);
    chk({tag, "_frame"}, frame_done, 1'b0);
    chk({tag, "_err"},   decode_err, 1'b0);
    chk({tag, "_dpf"},   dp_flags, 4'h0);
    chk({tag, "_state"}, state_dbg, S_IDLE);
    @(negedge clk);
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic was_latch;
    exp_t e;
    was_latch = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        was_latch = 1'b0;
      end else begin
        if (was_latch) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_latch actual=latch expected=none code=%0h t=%0t", digit_code, $time);
          end else begin
            e = exp_q.pop_front();
            chk("lat_code",  digit_code,  e.code);
            chk("lat_valid", digit_valid, e.valid);
            chk("lat_dpf",   dp_flags,    e.dpf);
            chk("lat_frame", frame_done,  e.frame);
            chk("lat_err",   decode_err,  e.err);
            if (frame_done) frame_cnt++;
          end
        end else begin
          chk("no_pulse", {frame_done, decode_err}, 2'b00);
        end
        was_latch = (state_dbg == S_LATCH);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int base;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    int h;
    logic [3:0] multi [7] = '{4'b1100, 4'b1010, 4'b0000, 4'b0110, 4'b1001, 4'b0011, 4'b0101};

    reset = 1'b1;
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_code",  digit_code, {4{5'd18}});
    chk("rst_valid", digit_valid, 4'h0);
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_dpf",   dp_flags, 4'h0);
    reset = 1'b0;

    // 1: digit 0 shows "2"; update lands exactly SETTLE+2 edges after apply
    drive(4'b1110, 7'b0100100, 1'b1, S + 2);
    chk("t1_valid_early", digit_valid, 4'b0000);
    drive(4'b1110, 7'b0100100, 1'b1, 1);
    chk("t1_valid_on_time", digit_valid, 4'b0001);
    chk("t1_code0", digit_code[4:0], 5'd2);
    drive(4'b1110, 7'b0100100, 1'b1, 2);

    // 2: scan 3, A, =, - across digits 0..3
    async_reset_check("rst2");
    base = frame_cnt;
    drive(4'b1110, 7'h30, 1'b1, 32);
    drive(4'b1101, 7'h08, 1'b1, 32);
    drive(4'b1011, 7'b0110111, 1'b1, 32);
    drive(4'b0111, 7'b0111111, 1'b1, 32);
    drive(4'b1111, 7'h7F, 1'b1, 4);
    chk("t2_codes", digit_code, {5'd17, 5'd16, 5'd10, 5'd3});
    chk("t2_frames", frame_cnt - base, 1);

    // 3: seg flips every 8 cycles on digit 1, never settles
    async_reset_check("rst3");
    base = frame_cnt;
    for (int k = 0; k < 8; k++) drive(4'b1101, k[0] ? 7'h79 : 7'h24, 1'b1, 8);
    chk("t3_valid1", digit_valid[1], 1'b0);

    // 4: invalid anode patterns keep the FSM idle
    drive(4'b1100, 7'h40, 1'b1, 64);
    chk("t4_state_multi", state_dbg, S_IDLE);
    chk("t4_valid", digit_valid, 4'h0);
    drive(4'b1111, 7'h40, 1'b1, 64);
    chk("t4_state_none", state_dbg, S_IDLE);

    // 5: unrecognised pattern on digit 2
    drive(4'b1011, 7'b1010101, 1'b1, S + 4);
    chk("t5_valid2", digit_valid[2], 1'b1);
    chk("t5_code2", digit_code[14:10], 5'd31);

    // 6: dp lit on digit 3, then complete the frame and reset
    drive(4'b0111, 7'h40, 1'b0, S + 4);
`ifdef DP_CAPTURE_EN
    chk("t6_dpf", dp_flags, 4'b1000);
`else
    chk("t6_dpf", dp_flags, 4'b0000);
`endif
    drive(4'b1110, 7'h19, 1'b1, S + 4);
    drive(4'b1101, 7'h12, 1'b1, S + 4);
    chk("t6_frames", frame_cnt - base, 1);
    async_reset_check("rst_frame");
    drive(4'b1110, 7'h24, 1'b1, 5);
    async_reset_check("rst_settle");
    drive(4'b1110, 7'h24, 1'b1, S + 4);
    chk("t6_relatch", digit_valid, 4'b0001);

    // random scan traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) != 0 || n == 0) begin
        if ($urandom_range(0, 9) == 0)
          a = ($urandom_range(0, 1) == 0) ? 4'hF : multi[$urandom_range(0, 6)];
        else
          a = ~(4'b0001 << $urandom_range(0, 3));
        h = $urandom_range(0, 19);
        if (h < 16)       s = hex_pat[h];
        else if (h == 16) s = 7'b0110111;
        else if (h == 17) s = 7'b0111111;
        else if (h == 18) s = 7'b1111111;
        else              s = 7'($urandom_range(0, 127));
        d = 1'($urandom_range(0, 1));
      end
      h = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S) : $urandom_range(S + 1, S + 24);
      drive(a, s, d, h);
    end

    drive(4'b1111, 7'h7F, 1'b1, S + 4);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
